imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams bytes from a source into 32-bit instruction-memory
// words while holding the core in reset, then releases it.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-low reset
//   start        one-cycle load request, honoured only when idle
//   base_addr    byte address of the first word (low two bits dropped)
//   word_count   number of 32-bit words to load, captured with start
//   byte_valid   source byte present
//   byte_data    source byte
//   byte_ready   loader accepts a byte this cycle
//   mem_we       instruction-memory write request
//   mem_addr     word-aligned write address
//   mem_wdata    assembled little-endian write word
//   mem_ack      memory accepted the write this cycle
//   hold_core    keeps the core in reset while a load is in progress
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse on successful completion
//   err          sticky timeout flag, cleared by the next accepted start
module imem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        hold_core,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic [31:0]       addr_q,       addr_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [31:0]       word_q,       word_d;
    logic [TO_W-1:0]   to_cnt_q,     to_cnt_d;
    logic              err_q,        err_d;
    logic              hold_core_q,  hold_core_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
            hold_core_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            hold_core_q  <= hold_core_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr & ~32'd3;
                    words_left_d = word_count;
                    err_d        = 1'b0;
                    byte_cnt_d   = '0;
                    word_d       = '0;
                    to_cnt_d     = '0;
                    state_d      = (word_count != 16'd0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    // Little-endian: byte k lands in bits [8k+7:8k].
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    to_cnt_d   = '0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle brings the count to the limit: abandon
                    // the partial word without writing and without done.
                    err_d      = 1'b1;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    addr_d       = addr_q + 32'd4;
                    words_left_d = words_left_q - 16'd1;
                    byte_cnt_d   = '0;
                    to_cnt_d     = '0;
                    state_d      = (words_left_q == 16'd1) ? DONE : COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered copy of busy that tracks it cycle-for-cycle.
        hold_core_d = (state_d != IDLE);
    end

    assign byte_ready = (state_q == COLLECT);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = word_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign hold_core  = hold_core_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        hold_core;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .hold_core(hold_core),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting bytes, 2 writing, 3 done pulse
    int          m_mode = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_word = '0;
    int          m_left = 0;
    int          m_n    = 0;
    int          m_to   = 0;
    logic        m_err  = 1'b0;

    task automatic model_step();
        if (!rst) begin
            m_mode = 0; m_addr = '0; m_word = '0; m_left = 0;
            m_n = 0; m_to = 0; m_err = 1'b0;
            return;
        end
        case (m_mode)
            0: if (start) begin
                m_addr = {base_addr[31:2], 2'b00};
                m_left = int'(word_count);
                m_err = 1'b0; m_n = 0; m_word = '0; m_to = 0;
                m_mode = (word_count != 0) ? 1 : 3;
            end
            1: if (byte_valid) begin
                m_word = m_word | (32'(byte_data) << (8 * m_n));
                m_n++;
                m_to = 0;
                if (m_n == 4) m_mode = 2;
            end else begin
                m_to++;
                if (m_to == TO) begin
                    m_err = 1'b1; m_mode = 0; m_to = 0; m_n = 0; m_word = '0;
                end
            end
            2: if (mem_ack) begin
                m_addr = m_addr + 32'd4;
                m_left--;
                m_n = 0; m_word = '0; m_to = 0;
                m_mode = (m_left == 0) ? 3 : 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    // ---------------- compare / monitor ----------------
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          n_done = 0;
    int          n_we = 0;
    int          we_run = 0;
    int          last_we_len = 0;
    logic        prev_we = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    initial forever begin
        @(negedge clk);
        chk("byte_ready", byte_ready, (m_mode == 1));
        chk("mem_we",     mem_we,     (m_mode == 2));
        chk("busy",       busy,       (m_mode != 0));
        chk("done",       done,       (m_mode == 3));
        chk("hold_core",  hold_core,  (m_mode != 0));
        chk("err",        err,        m_err);
        chk("mem_addr",   mem_addr,   m_addr);
        if (m_mode == 2 || !rst) chk("mem_wdata", mem_wdata, (m_mode == 2) ? m_word : 32'd0);
        if (prev_we && !prev_ack && mem_we) begin
            chk("addr_stable", mem_addr, prev_addr);
            chk("data_stable", mem_wdata, prev_data);
        end
        if (done) n_done++;
        if (mem_we) begin
            n_we++;
            we_run++;
            if (mem_ack) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                last_we_len = we_run;
            end
        end else begin
            we_run = 0;
        end
        prev_we = mem_we; prev_ack = mem_ack;
        prev_addr = mem_addr; prev_data = mem_wdata;
    end

    // ---------------- memory ack responder ----------------
    int ack_delay = 0;
    bit ack_noise = 1'b0;

    initial begin
        int w;
        w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_we) begin
                mem_ack = (w >= ack_delay);
                w++;
            end else begin
                w = 0;
                mem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic start_load(input logic [31:0] base, input logic [15:0] cnt);
        start = 1'b1; base_addr = base; word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        bit acc;
        for (int g = 0; g < gap; g++) begin
            start = inj && ($urandom_range(0, 3) == 0);
            base_addr = $urandom; word_count = 16'($urandom_range(1, 3));
            @(posedge clk); #1;
        end
        start = 1'b0;
        byte_valid = 1'b1; byte_data = b;
        acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if (byte_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; byte_data = 8'($urandom);
        chk("byte_accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_idle", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] base, wd;
        logic [7:0]  bb;
        int          cnt, k, nd, nw;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_hold", hold_core, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Two words back to back, immediate ack
        log_addr.delete(); log_data.delete(); n_done = 0;
        start_load(32'h100, 16'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), 0, 1'b0);
        wait_idle();
        chk("t1_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t1_addr0", log_addr[0], 32'h100);
            chk("t1_data0", log_data[0], 32'h44332211);
            chk("t1_addr1", log_addr[1], 32'h104);
            chk("t1_data1", log_data[1], 32'h88776655);
        end
        chk("t1_done", n_done, 1);
        chk("t1_hold", hold_core, 0);

        // Unaligned base address
        log_addr.delete(); log_data.delete();
        start_load(32'h103, 16'd1);
        send_byte(8'hA1, 0, 1'b0); send_byte(8'hB2, 1, 1'b0);
        send_byte(8'hC3, 2, 1'b0); send_byte(8'hD4, 0, 1'b0);
        wait_idle();
        chk("t2_nwrites", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t2_addr", log_addr[0], 32'h100);
            chk("t2_data", log_data[0], 32'hD4C3B2A1);
        end

        // Zero-word load
        n_we = 0; n_done = 0;
        start_load(32'h80, 16'd0);
        chk("t3_done_hi", done, 1);
        chk("t3_busy", busy, 1);
        @(posedge clk); #1;
        chk("t3_done_lo", done, 0);
        chk("t3_idle", busy, 0);
        @(posedge clk); #1;
        chk("t3_ndone", n_done, 1);
        chk("t3_nwe", n_we, 0);

        // Delayed ack
        ack_delay = 3;
        log_addr.delete(); log_data.delete();
        start_load(32'h40, 16'd1);
        send_byte(8'h01, 0, 1'b0); send_byte(8'h02, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0); send_byte(8'h04, 0, 1'b0);
        wait_idle();
        chk("t4_we_len", last_we_len, 4);
        if (log_data.size() == 1) chk("t4_data", log_data[0], 32'h04030201);
        else chk("t4_nwrites", log_data.size(), 1);
        ack_delay = 0;

        // Timeout after two bytes
        log_addr.delete(); log_data.delete(); n_done = 0;
        start_load(32'h200, 16'd1);
        send_byte(8'h5A, 0, 1'b0); send_byte(8'h6B, 0, 1'b0);
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_to_len", k, TO);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 0);
        chk("t5_nwrites", log_addr.size(), 0);
        chk("t5_done", n_done, 0);
        start_load(32'h300, 16'd1);
        chk("t5_err_clr", err, 0);
        send_byte(8'h10, 0, 1'b0); send_byte(8'h20, 0, 1'b0);
        send_byte(8'h30, 0, 1'b0); send_byte(8'h40, 0, 1'b0);
        wait_idle();
        if (log_addr.size() == 1) begin
            chk("t5_addr", log_addr[0], 32'h300);
            chk("t5_data", log_data[0], 32'h40302010);
        end else chk("t5_nwrites2", log_addr.size(), 1);

        // Reset during WRITE
        ack_delay = 6;
        start_load(32'h500, 16'd2);
        send_byte(8'hE1, 0, 1'b0); send_byte(8'hE2, 0, 1'b0);
        send_byte(8'hE3, 0, 1'b0); send_byte(8'hE4, 0, 1'b0);
        chk("t6_in_write", mem_we, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_ready", byte_ready, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_hold", hold_core, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        nw = n_we; nd = n_done;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ack_delay = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_we", n_we, nw);
        chk("t6_no_done", n_done, nd);
        log_addr.delete(); log_data.delete();
        start_load(32'h600, 16'd1);
        send_byte(8'h0D, 0, 1'b0); send_byte(8'h0C, 0, 1'b0);
        send_byte(8'h0B, 0, 1'b0); send_byte(8'h0A, 0, 1'b0);
        wait_idle();
        if (log_addr.size() == 1) begin
            chk("t6_addr_ok", log_addr[0], 32'h600);
            chk("t6_data_ok", log_data[0], 32'h0A0B0C0D);
        end else chk("t6_nwrites", log_addr.size(), 1);

        // Randomised loads with ack delays, ack noise and ignored starts
        ack_noise = 1'b1;
        for (int t = 0; t < 25; t++) begin
            wait_idle();
            base = $urandom;
            cnt = $urandom_range(0, 4);
            ack_delay = $urandom_range(0, 3);
            log_addr.delete(); log_data.delete(); n_done = 0;
            ea.delete(); ed.delete();
            start_load(base, 16'(cnt));
            for (int w = 0; w < cnt; w++) begin
                wd = '0;
                for (int b = 0; b < 4; b++) begin
                    bb = 8'($urandom);
                    wd = wd | (32'(bb) << (8 * b));
                    send_byte(bb, $urandom_range(0, 5), 1'b1);
                end
                ea.push_back((base & ~32'd3) + 32'(4 * w));
                ed.push_back(wd);
            end
            wait_idle();
            chk("rnd_nwrites", log_addr.size(), ea.size());
            chk("rnd_done", n_done, 1);
            for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
                chk("rnd_addr", log_addr[i], ea[i]);
                chk("rnd_data", log_data[i], ed[i]);
            end
        end
        ack_noise = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
